clk_divider_bank: RTL and testbench
===================================

# clk_divider_bank

Multi-channel programmable clock divider. It generates NUM_CH independent slow outputs from the single system clock, each running as either a 50%-duty toggled clock or a one-cycle strobe. Divisor and mode are runtime-writable through a simple config port and take effect glitch-free at the channel's next period boundary. It replaces single fixed-width dividers wherever the design needs debounce sample ticks, display refresh or 1 Hz game timing.

## Interface
- NUM_CH, 2: number of independent channels (1..8).
- WIDTH, 22: counter and divisor width in bits.
- DEFAULT_DIV, 22'h3FFFFF: divisor loaded into every channel at reset.
- clk_in  input  1  system clock (40 MHz).
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  NUM_CH  per-channel run enable.
- sync  input  1  one-cycle pulse that phase-aligns all channels.
- cfg_we  input  1  config write strobe.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_div  input  WIDTH  new divisor value.
- cfg_mode  input  1  new mode: 0 = toggle, 1 = strobe.
- div_out  output  NUM_CH  divided clock (toggle mode) or tick (strobe mode), registered.
- cfg_pending  output  NUM_CH  high while a written config is waiting to be applied.

## Operation
- Per channel: counter cnt, active divisor/mode, shadow divisor/mode, pending flag.
- Wrap condition: en high and cnt == active divisor. At wrap, cnt <= 0; otherwise, while en is high, cnt <= cnt + 1.
- Toggle mode: div_out inverts at each wrap. Output period is 2*(div+1) cycles, 50% duty. div = 0 gives clk_in/2.
- Strobe mode: div_out is high for exactly the one cycle after each wrap edge and low otherwise. Period is div+1 cycles. div = 0 gives div_out held high while enabled.
- en low: cnt holds its value. Toggle output holds its level; strobe output is 0. When en returns high, counting resumes from the held cnt.
- Config write (cfg_we high, cfg_ch < NUM_CH): the shadow is loaded and pending is set. Writes with cfg_ch >= NUM_CH are ignored.
- Apply rules:
  - The shadow is copied to active at the next wrap, or on the next cycle if en is low. Pending then clears.
  - A write in the same cycle as a wrap applies the new values at that wrap (bypass).
  - A second write before apply overwrites the shadow; last write wins.
- Mode change on apply: cnt <= 0 and div_out <= 0.
- sync pulse: every channel's cnt <= 0 and div_out <= 0, including disabled channels. Pending config is applied at the same time. sync wins over wrap and over en.
- All arithmetic is unsigned WIDTH-bit. cnt never exceeds the active divisor. The increment never wraps, because cnt resets at the divisor.

## Timing
- Reset (rst_n low, async) sets per channel: cnt = 0, active = shadow = DEFAULT_DIV, mode = toggle, div_out = 0, cfg_pending = 0.
- Release of reset is synchronous to clk_in. The first count occurs on the first clk_in edge with rst_n high and en high.
- div_out changes on the clk_in edge where the wrap is detected, so it is registered with zero added latency.
- cfg_pending rises the cycle after cfg_we. It falls on the apply edge.
- Reset mid-period discards the count and any pending config.

## Structure
- Package clk_div_pkg holds:
  - mode constants MODE_TOGGLE = 1'b0 and MODE_STROBE = 1'b1;
  - the default WIDTH;
  - a channel-index width function.
- Sub-module clk_div_channel, one per channel via generate, contains the counter, shadow/active registers, apply logic and output register.
- The top level decodes cfg_ch into per-channel write enables and fans out sync.

## Test plan
- Reset, then en = 2'b11 with DEFAULT_DIV replaced by a write of div = 4 in toggle mode on ch0 -> div_out[0] has period 10 cycles at 50% duty; cfg_pending[0] clears at the first wrap.
- ch1 written div = 2, mode = strobe -> div_out[1] pulses high for one cycle every 3 cycles. Write div = 0 -> constant high after the next wrap.
- Mid-period write of div = 9 on ch0 running div = 4 -> the current period completes at 4, and the following half-periods are 10 cycles. A write coincident with a wrap takes effect immediately.
- en[0] dropped for 7 cycles at cnt = 2 -> cnt and div_out hold. After re-enable, the wrap occurs exactly 2 cycles later.
- Channels with div = 3 and div = 3 started at different times, then sync pulsed -> both div_out values are 0 next cycle and toggle in lockstep afterwards. A pending write on either channel is applied at sync.
- rst_n asserted asynchronously mid-count with a pending config -> all outputs are 0 immediately, divisors are back to DEFAULT_DIV, and cfg_pending = 0. A write with cfg_ch = NUM_CH has no effect.

Source files
------------

// File: rtl/clk_divider_bank_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;

  localparam logic MODE_TOGGLE   = 1'b0;
  localparam logic MODE_STROBE   = 1'b1;
  localparam int   DEFAULT_WIDTH = 22;

  function automatic int ch_idx_w(input int num_ch);
    if (num_ch <= 1) begin
      return 1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/clk_divider_bank_if.sv
// Configuration write port of the clock divider bank.
interface clk_divider_bank_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = clk_div_pkg::DEFAULT_WIDTH
);
  import clk_div_pkg::*;

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_mode;

  modport master (output cfg_we, output cfg_ch, output cfg_div, output cfg_mode);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div, input  cfg_mode);

endinterface

// File: rtl/clk_divider_bank_channel.sv
// One divider channel: counter, shadow/active config, boundary-aligned apply and registered output.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = {WIDTH{1'b1}}
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             mode_i,
  output logic             div_out_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d, act_div_q, act_div_d, sh_div_q, sh_div_d;
  logic             act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d, out_q, out_d;
  logic             wrap_s, apply_s, mode_chg_s, eff_mode_s, strobe_s;
  logic [WIDTH-1:0] eff_div_s;

  // Wrap/apply decode; a write coincident with a wrap or sync bypasses the shadow
  always_comb begin
    wrap_s     = en_i && (cnt_q == act_div_q);
    eff_div_s  = we_i ? div_i : sh_div_q;
    eff_mode_s = we_i ? mode_i : sh_mode_q;
    mode_chg_s = (eff_mode_s != act_mode_q);
    strobe_s   = (act_mode_q == MODE_STROBE);
    apply_s    = (we_i && (wrap_s || sync_i)) || (pend_q && (wrap_s || sync_i || !en_i));
  end

  // Next-state: sync beats everything, then mode-change apply, wrap, count, hold
  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    sh_div_d   = sh_div_q;
    sh_mode_d  = sh_mode_q;
    pend_d     = pend_q;
    out_d      = out_q;
    if (we_i) begin
      sh_div_d  = div_i;
      sh_mode_d = mode_i;
      pend_d    = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    if (apply_s) begin
      act_div_d  = eff_div_s;
      act_mode_d = eff_mode_s;
      pend_d     = 1'b0;
    end else begin
      act_div_d = act_div_q;
    end
    if (sync_i) begin
      cnt_d = {WIDTH{1'b0}};
      out_d = 1'b0;
    end else if (apply_s && mode_chg_s) begin
      cnt_d = {WIDTH{1'b0}};
      out_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d = {WIDTH{1'b0}};
      out_d = strobe_s ? 1'b1 : ~out_q;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      out_d = strobe_s ? 1'b0 : out_q;
    end else begin
      // A divisor shrunk while disabled must not strand cnt above it
      cnt_d = (apply_s && (cnt_q > eff_div_s)) ? {WIDTH{1'b0}} : cnt_q;
      out_d = strobe_s ? 1'b0 : out_q;
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {WIDTH{1'b0}};
      act_div_q  <= DEFAULT_DIV;
      act_mode_q <= MODE_TOGGLE;
      sh_div_q   <= DEFAULT_DIV;
      sh_mode_q  <= MODE_TOGGLE;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      act_mode_q <= act_mode_d;
      sh_div_q   <= sh_div_d;
      sh_mode_q  <= sh_mode_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
    end
  end

  assign div_out_o = out_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_divider_bank.sv
// Multi-channel programmable clock divider: toggle or strobe outputs with glitch-free reconfiguration.
module clk_divider_bank
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH      = 2,
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(22'h3FFFFF)
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  en,
  input  logic               sync,
  clk_divider_bank_if.slave  cfg,
  output logic [NUM_CH-1:0]  div_out,
  output logic [NUM_CH-1:0]  cfg_pending
);

  logic [NUM_CH-1:0] we_s;

  // Per-channel write strobes; out-of-range indices match no channel
  always_comb begin
    we_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_we && (int'(cfg.cfg_ch) == i)) begin
        we_s[i] = 1'b1;
      end else begin
        we_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en_i      (en[g]),
      .sync_i    (sync),
      .we_i      (we_s[g]),
      .div_i     (cfg.cfg_div),
      .mode_i    (cfg.cfg_mode),
      .div_out_o (div_out[g]),
      .pending_o (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Scoreboard bench for clk_divider_bank: a cycle model queues expected outputs, plus directed period checks.
module tb_clk_divider_bank;
  import clk_div_pkg::*;

  localparam int             NCH  = 3;
  localparam int             W    = 22;
  localparam logic [W-1:0]   DDIV = 22'd7;

  logic           clk_in = 1'b0;
  logic           rst_n  = 1'b1;
  logic           sync   = 1'b0;
  logic [NCH-1:0] en     = '0;
  logic [NCH-1:0] div_out, cfg_pending;

  clk_divider_bank_if #(.NUM_CH(NCH), .WIDTH(W)) cfg_if ();

  clk_divider_bank #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .cfg         (cfg_if),
    .div_out     (div_out),
    .cfg_pending (cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  logic [W-1:0]     m_cnt [NCH];
  logic [W-1:0]     m_div [NCH];
  logic [W-1:0]     m_sdiv[NCH];
  logic             m_mode[NCH], m_smode[NCH], m_pend[NCH], m_out[NCH];
  logic [2*NCH-1:0] exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = '0; m_div[c] = DDIV; m_sdiv[c] = DDIV;
      m_mode[c] = 1'b0; m_smode[c] = 1'b0; m_pend[c] = 1'b0; m_out[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      logic we, wrap, ap, chg, em;
      logic [W-1:0] ed;
      we   = cfg_if.cfg_we && (int'(cfg_if.cfg_ch) == c);
      wrap = en[c] && (m_cnt[c] == m_div[c]);
      ed   = we ? cfg_if.cfg_div : m_sdiv[c];
      em   = we ? cfg_if.cfg_mode : m_smode[c];
      if (we) begin m_sdiv[c] = cfg_if.cfg_div; m_smode[c] = cfg_if.cfg_mode; end
      if (sync) begin
        if (we || m_pend[c]) begin m_div[c] = ed; m_mode[c] = em; end
        m_pend[c] = 1'b0; m_cnt[c] = '0; m_out[c] = 1'b0;
      end else begin
        ap = (we && wrap) || (m_pend[c] && (wrap || !en[c]));
        if (we) m_pend[c] = 1'b1;
        if (ap) begin
          chg = (em != m_mode[c]);
          m_div[c] = ed; m_mode[c] = em; m_pend[c] = 1'b0;
          if (chg) begin m_cnt[c] = '0; m_out[c] = 1'b0; end
          else if (wrap) begin m_cnt[c] = '0; m_out[c] = em ? 1'b1 : ~m_out[c]; end
          else begin
            if (m_cnt[c] > ed) m_cnt[c] = '0;
            if (em) m_out[c] = 1'b0;
          end
        end else if (wrap) begin
          m_cnt[c] = '0; m_out[c] = m_mode[c] ? 1'b1 : ~m_out[c];
        end else if (en[c]) begin
          m_cnt[c] = m_cnt[c] + 22'd1;
          if (m_mode[c]) m_out[c] = 1'b0;
        end else if (m_mode[c]) begin
          m_out[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    logic [2*NCH-1:0] e;
    if (!rst_n) model_reset(); else model_step();
    for (int c = 0; c < NCH; c++) begin
      e[c] = m_out[c]; e[NCH+c] = m_pend[c];
    end
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check("div_out", 32'(div_out), 32'(e[NCH-1:0]));
    check("cfg_pending", 32'(cfg_pending), 32'(e[2*NCH-1:NCH]));
  endtask

  task automatic wr(input logic [1:0] ch, input logic [W-1:0] dv, input logic md);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = ch; cfg_if.cfg_div = dv; cfg_if.cfg_mode = md;
    tick();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic wait_pend_clear(input int ch, output int n);
    n = 0;
    while (cfg_pending[ch] === 1'b1 && n < 60) begin tick(); n++; end
    check("pend_timeout", 32'(n >= 60), 32'd0);
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    int b;
    b = 0; hi = 0; lo = 0;
    while (div_out[ch] !== 1'b0 && b < 100) begin tick(); b++; end
    while (div_out[ch] !== 1'b1 && b < 200) begin tick(); b++; end
    while (div_out[ch] === 1'b1 && b < 300) begin tick(); hi++; b++; end
    while (div_out[ch] === 1'b0 && b < 400) begin tick(); lo++; b++; end
    check("measure_timeout", 32'(b >= 400), 32'd0);
  endtask

  initial begin
    int hi, lo, n;
    logic lv;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_mode = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_div_out", 32'(div_out), 32'd0);
    check("reset_pending", 32'(cfg_pending), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // toggle div 4 on ch0, written while the default divisor runs
    en = 3'b011;
    tick(); tick();
    wr(2'd0, 22'd4, MODE_TOGGLE);
    check("pend_rise", 32'(cfg_pending[0]), 32'd1);
    wait_pend_clear(0, n);
    check("first_wrap_lat", 32'(n), 32'd5);
    check("first_wrap_out", 32'(div_out[0]), 32'd1);
    measure(0, hi, lo);
    check("tog4_hi", 32'(hi), 32'd5);
    check("tog4_lo", 32'(lo), 32'd5);

    // strobe div 2, then div 0 on ch1
    wr(2'd1, 22'd2, MODE_STROBE);
    wait_pend_clear(1, n);
    measure(1, hi, lo);
    check("strb2_hi", 32'(hi), 32'd1);
    check("strb2_lo", 32'(lo), 32'd2);
    wr(2'd1, 22'd0, MODE_STROBE);
    wait_pend_clear(1, n);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("strb0_high", 32'(div_out[1]), 32'd1);
    end
    wr(2'd1, 22'd3, MODE_TOGGLE);

    // mid-period write: current period finishes at 4, then 10-cycle halves
    n = 0;
    while (m_cnt[0] != 22'd1 && n < 20) begin tick(); n++; end
    wr(2'd0, 22'd9, MODE_TOGGLE);
    wait_pend_clear(0, n);
    check("midwr_lat", 32'(n), 32'd3);
    measure(0, hi, lo);
    check("tog9_hi", 32'(hi), 32'd10);
    check("tog9_lo", 32'(lo), 32'd10);

    // write coincident with a wrap applies immediately
    n = 0;
    while (m_cnt[0] != m_div[0] && n < 30) begin tick(); n++; end
    wr(2'd0, 22'd3, MODE_TOGGLE);
    check("bypass_pend", 32'(cfg_pending[0]), 32'd0);
    measure(0, hi, lo);
    check("tog3_hi", 32'(hi), 32'd4);
    check("tog3_lo", 32'(lo), 32'd4);

    // enable dropped at cnt 2 for 7 cycles
    n = 0;
    while (m_cnt[0] != 22'd2 && n < 20) begin tick(); n++; end
    lv = m_out[0];
    en[0] = 1'b0;
    repeat (7) tick();
    check("en_hold", 32'(div_out[0]), 32'(lv));
    en[0] = 1'b1;
    n = 0;
    while (div_out[0] === lv && n < 20) begin tick(); n++; end
    check("reen_lat", 32'(n), 32'd2);

    // pending write then sync: both channels lock together
    n = 0;
    while (m_cnt[0] == m_div[0] && n < 10) begin tick(); n++; end
    wr(2'd0, 22'd3, MODE_TOGGLE);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_out", 32'(div_out[1:0]), 32'd0);
    check("sync_pend", 32'(cfg_pending), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("lockstep", 32'(div_out[1:0]), ((k / 4) % 2 == 1) ? 32'd3 : 32'd0);
    end

    // asynchronous reset mid-count with a pending write
    n = 0;
    while (m_cnt[1] == m_div[1] && n < 10) begin tick(); n++; end
    wr(2'd1, 22'd9, MODE_TOGGLE);
    check("pend_before_rst", 32'(cfg_pending[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_out", 32'(div_out), 32'd0);
    check("async_rst_pend", 32'(cfg_pending), 32'd0);
    tick();
    rst_n = 1'b1;
    en = 3'b001;
    wr(2'd3, 22'd1, MODE_STROBE);
    check("bad_ch_pend", 32'(cfg_pending), 32'd0);
    measure(0, hi, lo);
    check("default_hi", 32'(hi), 32'd8);
    check("default_lo", 32'(lo), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
